// File: rtl/lemon_pkg.sv
// rtl/lemon_pkg.sv - shared constants and state encoding for the lemon fetch unit
package lemon_pkg;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/lemon_ifu.sv
// rtl/lemon_ifu.sv - single-outstanding instruction fetch unit feeding the execute core
module lemon_ifu #(
    parameter int XLEN = lemon_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = lemon_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            req_valid,
    output logic [XLEN-1:0] req_addr,
    input  logic            req_ready,
    input  logic            resp_valid,
    input  logic [31:0]     resp_data,
    input  logic            resp_err,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt
);
    import lemon_pkg::*;

    ifu_state_e      state;
    logic [XLEN-1:0] pc;
    logic            drop;
    logic [XLEN-1:0] redir_pc;

    // Redirect targets are forced onto a word boundary so req_addr stays aligned.
    assign redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};
    assign req_valid = (state == S_REQ) & ~redirect_valid & ~halt & rst_n;
    assign req_addr  = pc;

    // Fetch FSM: owns the PC, the drop flag for stale responses and the held instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_fault <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (halt) begin
                        state <= S_HALT;
                    end else if (redirect_valid) begin
                        pc <= redir_pc;
                    end else if (req_valid && req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The bus request cannot be withdrawn, so a redirect only marks its response stale.
                    if (redirect_valid) begin
                        pc <= redir_pc;
                    end
                    if (resp_valid) begin
                        if (drop || redirect_valid) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            inst       <= resp_data;
                            inst_pc    <= pc;
                            inst_fault <= resp_err;
                            inst_valid <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        pc         <= redirect_valid ? redir_pc : pc + XLEN'(4);
                        inst_valid <= 1'b0;
                        if (halt) begin
                            state      <= S_HALT;
                            inst       <= '0;
                            inst_pc    <= '0;
                            inst_fault <= 1'b0;
                        end else begin
                            state <= S_REQ;
                        end
                    end else if (halt) begin
                        state      <= S_HALT;
                        inst_valid <= 1'b0;
                        inst       <= '0;
                        inst_pc    <= '0;
                        inst_fault <= 1'b0;
                    end else if (redirect_valid) begin
                        pc         <= redir_pc;
                        inst_valid <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    // Memory must only answer the single request we are waiting on.
    resp_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        resp_valid |-> (state == S_WAIT));

endmodule

// File: tb/tb_lemon_ifu.sv
// tb/tb_lemon_ifu.sv - scoreboard bench for lemon_ifu with randomized memory and core
module tb_lemon_ifu;

    localparam logic [63:0] RPC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready = 1'b0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        resp_err = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        halt = 1'b0;

    int compared = 0;
    int mismatched = 0;

    logic [63:0] exp_q[$];
    bit          halted = 1'b0;
    int          cyc = 0;
    int          req_cycles[$];
    logic [63:0] req_addrs[$];
    logic [63:0] delivered[$];

    bit          pending = 1'b0;
    int          cnt = 0;
    logic [63:0] paddr = '0;
    int          lat_fix = 0;
    int          rdy_mode = 1;

    always #5 clk = ~clk;

    lemon_ifu dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
        .inst_ready(inst_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt)
    );

    function automatic logic [31:0] mem_word(logic [63:0] a);
        if (a == 64'h8000_0000) return 32'h0010_0093;
        if (a == 64'h8000_0004) return 32'h0020_0113;
        return a[31:0] ^ 32'hC0DE_0013;
    endfunction

    function automatic logic mem_err(logic [63:0] a);
        return (a == 64'h8000_0008) || (a[5:2] == 4'd13);
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference model: the next instruction the core should see, from architectural fetch rules.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q = {RPC};
            halted = 1'b0;
        end else if (!halted) begin
            if (halt && inst_valid) begin
                halted = 1'b1;
            end else if (redirect_valid) begin
                exp_q = {{redirect_pc[63:2], 2'b00}};
            end else if (inst_valid && inst_ready) begin
                logic [63:0] nxt;
                nxt = exp_q.pop_front() + 64'd4;
                exp_q.push_back(nxt);
            end
        end
    end

    // Memory model: accept requests, answer after a fixed or random latency.
    always @(posedge clk) begin
        if (!rst_n) begin
            pending = 1'b0;
            cyc = 0;
        end else begin
            cyc++;
            if (delivered.size() < 1000 && inst_valid && inst_ready) delivered.push_back(inst_pc);
            if (req_valid && req_ready) begin
                if (pending) begin
                    compared++;
                    mismatched++;
                    $display("FAIL dup_req: request at %0h while one outstanding", req_addr);
                end
                pending = 1'b1;
                paddr = req_addr;
                cnt = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
                req_cycles.push_back(cyc);
                req_addrs.push_back(req_addr);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        resp_valid = 1'b0;
        if (pending) begin
            if (cnt == 0) begin
                resp_valid = 1'b1;
                resp_data = mem_word(paddr);
                resp_err = mem_err(paddr);
                pending = 1'b0;
            end else begin
                cnt--;
            end
        end
        case (rdy_mode)
            0: req_ready = ($urandom_range(0, 3) != 0);
            1: req_ready = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    // Monitor: compare whatever the DUT presents against the scoreboard head.
    always @(negedge clk) begin
        #4;
        if (rst_n) begin
            if (halted) begin
                check("halt_req_valid", req_valid, 1'b0);
                check("halt_inst_valid", inst_valid, 1'b0);
            end else begin
                if (req_valid) check("req_addr", req_addr, exp_q[0]);
                if (inst_valid)
                    check("inst_triplet", {inst_fault, inst, inst_pc},
                          {mem_err(exp_q[0]), mem_word(exp_q[0]), exp_q[0]});
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_inst", {inst_fault, inst, inst_pc}, '0);
        req_cycles.delete();
        req_addrs.delete();
        delivered.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(string name, int budget);
        for (int n = 0; n < budget; n++) begin
            if (inst_valid) return;
            step();
        end
        check({name, "_timeout"}, inst_valid, 1'b1);
    endtask

    task automatic wait_req(string name, int budget);
        for (int n = 0; n < budget; n++) begin
            if (req_addrs.size() != 0) return;
            step();
        end
        check({name, "_timeout"}, req_addrs.size(), 1);
    endtask

    initial begin
        logic [31:0] cap_inst;
        logic [63:0] cap_pc;
        exp_q = {RPC};

        // zero-wait memory, core always ready
        rdy_mode = 1;
        lat_fix = 0;
        inst_ready = 1'b1;
        do_reset();
        repeat (8) step();
        check("t1_req_cycle0", req_cycles.size() > 0 ? req_cycles[0] : -1, 1);
        check("t1_req_cycle1", req_cycles.size() > 1 ? req_cycles[1] : -1, 4);
        check("t1_pc0", delivered.size() > 0 ? delivered[0] : '1, 64'h8000_0000);
        check("t1_pc1", delivered.size() > 1 ? delivered[1] : '1, 64'h8000_0004);

        // slow request acceptance and slow response
        rdy_mode = 2;
        lat_fix = 4;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_req_valid", req_valid, 1'b1);
            check("t2_req_addr", req_addr, RPC);
            if (i == 1) rdy_mode = 1;
        end
        wait_valid("t2", 20);
        check("t2_inst_pc", inst_pc, RPC);
        check("t2_inst", inst, 32'h0010_0093);
        check("t2_req_count", req_cycles.size(), 1);

        // redirect while waiting on memory
        lat_fix = 3;
        for (int n = 0; n < 20 && !pending; n++) step();
        check("t3_pending", pending, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0103;
        req_addrs.delete();
        step();
        redirect_valid = 1'b0;
        wait_req("t3_req", 20);
        check("t3_req_addr", req_addrs.size() > 0 ? req_addrs[0] : '1, 64'h8000_0100);
        wait_valid("t3", 20);
        check("t3_inst_pc", inst_pc, 64'h8000_0100);

        // back-pressure from the core, then handshake with redirect
        inst_ready = 1'b0;
        wait_valid("t4", 20);
        cap_inst = inst;
        cap_pc = inst_pc;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_hold_valid", inst_valid, 1'b1);
            check("t4_hold_inst", {inst, inst_pc}, {cap_inst, cap_pc});
            check("t4_no_req", req_valid, 1'b0);
        end
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0200;
        req_addrs.delete();
        step();
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        wait_req("t4_req", 20);
        check("t4_req_addr", req_addrs.size() > 0 ? req_addrs[0] : '1, 64'h8000_0200);

        // faulting fetch, squashing the held instruction
        wait_valid("t5a", 20);
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0008;
        step();
        redirect_valid = 1'b0;
        wait_valid("t5", 20);
        check("t5_fault", inst_fault, 1'b1);
        check("t5_inst_pc", inst_pc, 64'h8000_0008);
        inst_ready = 1'b1;
        req_addrs.delete();
        step();
        inst_ready = 1'b0;
        wait_req("t5_req", 20);
        check("t5_next_addr", req_addrs.size() > 0 ? req_addrs[0] : '1, 64'h8000_000C);

        // halt while holding with a handshake, then recover through reset
        wait_valid("t6", 20);
        halt = 1'b1;
        inst_ready = 1'b1;
        step();
        halt = 1'b0;
        req_addrs.delete();
        for (int i = 0; i < 10; i++) begin
            step();
            check("t6_halt_req", req_valid, 1'b0);
        end
        check("t6_no_accept", req_addrs.size(), 0);
        do_reset();
        wait_req("t6_req", 20);
        check("t6_restart_addr", req_addrs.size() > 0 ? req_addrs[0] : '1, RPC);

        // randomized traffic on both sides
        rdy_mode = 0;
        lat_fix = -1;
        for (int i = 0; i < 800; i++) begin
            step();
            inst_ready = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc = RPC + 64'($urandom_range(0, 1023));
        end
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
